// File: rtl/ram_sdp_gen_pkg.sv
// ram_sdp_gen_pkg: types and constants for the ram_sdp_gen block.
//   clr_state_e : clear-sweep FSM state (CLEAR, IDLE)
//   RDW_OLD/NEW : same-address read-during-write selection for RDW_MODE
package ram_sdp_gen_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_sdp_gen_clr.sv
// ram_sdp_gen_clr: clear-sweep controller for ram_sdp_gen.
// Walks an address counter over the whole array, one word per cycle, and
// reports the address/enable the array should use to write INIT_VAL.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset (starts a sweep from address 0)
//   CLR   : request a (re)start of the sweep from address 0
//   BUSY  : sweep in progress (registered, 1 exactly while state is CLEAR)
//   CADDR : address being cleared this cycle
//   CWE   : clear write enable
module ram_sdp_gen_clr
  import ram_sdp_gen_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLR,
  output logic              BUSY,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CWE
);

  clr_state_e        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= CLEAR;
      cnt   <= '0;
      BUSY  <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          if (CLR) begin
            cnt <= '0;
          end else if (cnt == '1) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (CLR) begin
            state <= CLEAR;
            BUSY  <= 1'b1;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign CADDR = cnt;
  assign CWE   = BUSY;

endmodule

// File: rtl/ram_sdp_gen.sv
// ram_sdp_gen: simple dual-port RAM (one write port, one read port) with a
// hardware clear sweep after reset or on request.
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), OUT_REG (0 async read,
//   1 registered read), RDW_MODE (RDW_OLD / RDW_NEW), INIT_VAL (sweep value).
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset
//   CLR   : request a clear sweep
//   BUSY  : clear sweep in progress (writes ignored, reads return INIT_VAL)
//   WRE/WAD/DI : write enable, address, data
//   RE    : read enable (registered read only)
//   RAD   : read address
//   DO    : read data
// Optional: define RAM_SDP_GEN_PARITY_EN to store an even-parity bit per word
//   and add PINJ (invert stored parity on write) and PERR (read parity error).
module ram_sdp_gen
  import ram_sdp_gen_pkg::*;
#(
  parameter int              DATA_W   = 2,
  parameter int              ADDR_W   = 4,
  parameter int              OUT_REG  = 0,
  parameter int              RDW_MODE = RDW_OLD,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLR,
  output logic              BUSY,
  input  logic              WRE,
  input  logic [ADDR_W-1:0] WAD,
  input  logic [DATA_W-1:0] DI,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RAD,
  output logic [DATA_W-1:0] DO
`ifdef RAM_SDP_GEN_PARITY_EN
  ,
  input  logic              PINJ,
  output logic              PERR
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef RAM_SDP_GEN_PARITY_EN
  // Stored word = {parity, data}; parity bit makes the word XOR to zero.
  localparam int WORD_W = DATA_W + 1;
  localparam logic [WORD_W-1:0] INIT_WORD = {^INIT_VAL, INIT_VAL};
  logic [WORD_W-1:0] wr_word;
  assign wr_word = {(^DI) ^ PINJ, DI};
`else
  localparam int WORD_W = DATA_W;
  localparam logic [WORD_W-1:0] INIT_WORD = INIT_VAL;
  logic [WORD_W-1:0] wr_word;
  assign wr_word = DI;
`endif

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;

  ram_sdp_gen_clr #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .CLK  (CLK),
    .RESET(RESET),
    .CLR  (CLR),
    .BUSY (BUSY),
    .CADDR(clr_addr),
    .CWE  (clr_we)
  );

  logic [WORD_W-1:0] mem [DEPTH];

  // Array has no reset; the sweep is what initialises it.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_WORD;
    end else if (WRE) begin
      mem[WAD] <= wr_word;
    end
  end

  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] out_word;

  // Read-path word as seen before the coming edge: INIT while sweeping,
  // the incoming write data when bypass is selected, else the array.
  always_comb begin
    rd_word = mem[RAD];
    if (BUSY) begin
      rd_word = INIT_WORD;
    end else if ((RDW_MODE == RDW_NEW) && WRE && (RAD == WAD)) begin
      rd_word = wr_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [WORD_W-1:0] do_q;
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          do_q <= '0;
        end else if (RE) begin
          do_q <= rd_word;
        end
      end
      assign out_word = do_q;
    end else begin : g_comb
      logic unused_re;
      assign unused_re = RE;
      assign out_word  = rd_word;
    end
  endgenerate

  assign DO = out_word[DATA_W-1:0];

`ifdef RAM_SDP_GEN_PARITY_EN
  assign PERR = (^out_word) & ~BUSY;
`endif

endmodule

// File: tb/tb_ram_sdp_gen.sv
module tb_ram_sdp_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, c_rst;
  logic       a_clr, a_wre;
  logic [3:0] a_wad, a_rad;
  logic [1:0] a_di;
  logic       b_wre, b_re;
  logic [3:0] b_wad, b_rad;
  logic [1:0] b_di;
  logic       c_clr, c_wre;
  logic [5:0] c_wad, c_rad;
  logic [7:0] c_di;

  logic       busy0, busy1, busy2, busy3, busy4;
  logic [1:0] do0, do1, do2, do3;
  logic [7:0] do4;

`ifdef RAM_SDP_GEN_PARITY_EN
  logic a_pinj;
  logic perr0, perr1, perr2, perr3, perr4;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // u0: defaults (async read, old data, INIT 0)
  ram_sdp_gen #(.DATA_W(2), .ADDR_W(4)) u0 (
    .CLK(clk), .RESET(rst), .CLR(a_clr), .BUSY(busy0), .WRE(a_wre), .WAD(a_wad),
    .DI(a_di), .RE(1'b0), .RAD(a_rad), .DO(do0)
`ifdef RAM_SDP_GEN_PARITY_EN
    , .PINJ(a_pinj), .PERR(perr0)
`endif
  );

  // u3: async read, INIT 2'b01, same stimulus as u0
  ram_sdp_gen #(.DATA_W(2), .ADDR_W(4), .INIT_VAL(2'b01)) u3 (
    .CLK(clk), .RESET(rst), .CLR(a_clr), .BUSY(busy3), .WRE(a_wre), .WAD(a_wad),
    .DI(a_di), .RE(1'b0), .RAD(a_rad), .DO(do3)
`ifdef RAM_SDP_GEN_PARITY_EN
    , .PINJ(a_pinj), .PERR(perr3)
`endif
  );

  // u1: registered read, new-data bypass
  ram_sdp_gen #(.DATA_W(2), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1)) u1 (
    .CLK(clk), .RESET(rst), .CLR(1'b0), .BUSY(busy1), .WRE(b_wre), .WAD(b_wad),
    .DI(b_di), .RE(b_re), .RAD(b_rad), .DO(do1)
`ifdef RAM_SDP_GEN_PARITY_EN
    , .PINJ(1'b0), .PERR(perr1)
`endif
  );

  // u2: registered read, old data
  ram_sdp_gen #(.DATA_W(2), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(0)) u2 (
    .CLK(clk), .RESET(rst), .CLR(1'b0), .BUSY(busy2), .WRE(b_wre), .WAD(b_wad),
    .DI(b_di), .RE(b_re), .RAD(b_rad), .DO(do2)
`ifdef RAM_SDP_GEN_PARITY_EN
    , .PINJ(1'b0), .PERR(perr2)
`endif
  );

  // u4: wide/deep variant
  ram_sdp_gen #(.DATA_W(8), .ADDR_W(6)) u4 (
    .CLK(clk), .RESET(c_rst), .CLR(c_clr), .BUSY(busy4), .WRE(c_wre), .WAD(c_wad),
    .DI(c_di), .RE(1'b0), .RAD(c_rad), .DO(do4)
`ifdef RAM_SDP_GEN_PARITY_EN
    , .PINJ(1'b0), .PERR(perr4)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wre;
    logic [3:0] wad;
    logic [1:0] di;
    logic [3:0] rad;
    logic [1:0] e0;   // expected u0 DO before the edge
    logic [1:0] e3;   // expected u3 DO before the edge
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd6,  2'd3, 4'd6,  2'd0, 2'd1};
    vecs[1] = '{1'b0, 4'd0,  2'd0, 4'd6,  2'd3, 2'd3};
    vecs[2] = '{1'b0, 4'd0,  2'd0, 4'd7,  2'd0, 2'd1};
    vecs[3] = '{1'b1, 4'd7,  2'd2, 4'd6,  2'd3, 2'd3};
    vecs[4] = '{1'b0, 4'd0,  2'd0, 4'd7,  2'd2, 2'd2};
    vecs[5] = '{1'b1, 4'd15, 2'd1, 4'd0,  2'd0, 2'd1};
    vecs[6] = '{1'b0, 4'd0,  2'd0, 4'd15, 2'd1, 2'd1};
    vecs[7] = '{1'b1, 4'd0,  2'd3, 4'd0,  2'd0, 2'd1};
    vecs[8] = '{1'b0, 4'd0,  2'd0, 4'd0,  2'd3, 2'd3};

    rst = 1'b0; c_rst = 1'b0;
    a_clr = 0; a_wre = 0; a_wad = '0; a_rad = '0; a_di = '0;
    b_wre = 0; b_re = 0; b_wad = '0; b_rad = '0; b_di = '0;
    c_clr = 0; c_wre = 0; c_wad = '0; c_rad = '0; c_di = '0;
`ifdef RAM_SDP_GEN_PARITY_EN
    a_pinj = 1'b0;
`endif
    #2 rst = 1'b1; c_rst = 1'b1;
    a_rad = 4'd7;
    #1;
    chk("rst_busy0", busy0, 1);
    chk("rst_do0", do0, 2'b00);
    chk("rst_do3_init", do3, 2'b01);
    chk("rst_do1_reg", do1, 2'b00);
    chk("rst_busy4", busy4, 1);

    // Initial sweep: BUSY high for exactly 16 edges after release
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sweep_busy0_e%0d", k), busy0, (k < 16) ? 1 : 0);
    end
    chk("sweep_busy1_done", busy1, 0);
    for (int a = 0; a < 16; a++) begin
      a_rad = 4'(a);
      #1;
      chk($sformatf("init_do0_a%0d", a), do0, 2'b00);
      chk($sformatf("init_do3_a%0d", a), do3, 2'b01);
    end

    // Write 3 to address 5, visible right after the edge
    @(negedge clk);
    a_wre = 1; a_wad = 4'd5; a_di = 2'b11; a_rad = 4'd5;
    @(posedge clk); #1;
    a_wre = 0;
    chk("wr5_do0", do0, 2'b11);
    chk("wr5_do3", do3, 2'b11);
    a_rad = 4'd4;
    #1;
    chk("rd4_do0", do0, 2'b00);
    chk("rd4_do3", do3, 2'b01);

    // Table: DO sampled before each edge (async read, old-data mode)
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_wre = vecs[i].wre; a_wad = vecs[i].wad; a_di = vecs[i].di; a_rad = vecs[i].rad;
      #1;
      chk($sformatf("vec%0d_do0", i), do0, vecs[i].e0);
      chk($sformatf("vec%0d_do3", i), do3, vecs[i].e3);
    end
    @(negedge clk);
    a_wre = 0;

    // Clear sweep restarted by CLR at sweep cycle 5; WRE during BUSY ignored
    a_clr = 1;
    @(negedge clk);
    a_clr = 0;
    chk("clr_busy3", busy3, 1);
    repeat (5) @(negedge clk);
    a_clr = 1; a_rad = 4'd7;
    #1;
    chk("busy_rd_do0", do0, 2'b00);
    chk("busy_rd_do3", do3, 2'b01);
    @(negedge clk);
    a_clr = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("reclr_busy3_e%0d", k), busy3, (k < 16) ? 1 : 0);
      if (k == 9) begin
        a_wre = 1; a_wad = 4'd2; a_di = 2'b11;
      end else begin
        a_wre = 0;
      end
    end
    for (int a = 0; a < 16; a++) begin
      a_rad = 4'(a);
      #1;
      chk($sformatf("clr_do0_a%0d", a), do0, 2'b00);
      chk($sformatf("clr_do3_a%0d", a), do3, 2'b01);
    end

`ifdef RAM_SDP_GEN_PARITY_EN
    @(negedge clk);
    a_wre = 1; a_wad = 4'd7; a_di = 2'b01; a_pinj = 1;
    @(negedge clk);
    a_wad = 4'd8; a_pinj = 0;
    @(negedge clk);
    a_wre = 0; a_rad = 4'd7;
    #1;
    chk("par7_do0", do0, 2'b01);
    chk("par7_perr0", perr0, 1);
    a_rad = 4'd8;
    #1;
    chk("par8_perr0", perr0, 0);
`endif

    // Registered read with same-address write: bypass vs old data
    @(negedge clk);
    b_wre = 1; b_wad = 4'd3; b_di = 2'b10; b_rad = 4'd3; b_re = 1;
    @(posedge clk); #1;
    chk("rdw_new_do1", do1, 2'b10);
    chk("rdw_old_do2", do2, 2'b00);
    @(negedge clk);
    b_wre = 0;
    @(posedge clk); #1;
    chk("rd3_do1", do1, 2'b10);
    chk("rd3_do2", do2, 2'b10);
    @(negedge clk);
    b_re = 0; b_rad = 4'd0;
    @(posedge clk); #1;
    chk("hold_do1", do1, 2'b10);
    chk("hold_do2", do2, 2'b10);
    @(negedge clk);
    b_re = 1;
    @(posedge clk); #1;
    chk("rd0_do1", do1, 2'b00);
    chk("rd0_do2", do2, 2'b00);

    // Wide variant: reset asserted mid-sweep at counter 20
    @(negedge clk);
    c_rst = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy4", busy4, 1);
    @(negedge clk);
    c_rst = 1; c_rad = 6'd20;
    #1;
    chk("rerst_busy4", busy4, 1);
    chk("rerst_do4", do4, 8'h00);
    @(negedge clk);
    c_rst = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 63 || k == 64)
        chk($sformatf("wide_busy4_e%0d", k), busy4, (k < 64) ? 1 : 0);
    end
    c_rad = 6'd0;  #1; chk("wide_do4_a0", do4, 8'h00);
    c_rad = 6'd63; #1; chk("wide_do4_a63", do4, 8'h00);
    @(negedge clk);
    c_wre = 1; c_wad = 6'd20; c_di = 8'h5A;
    @(negedge clk);
    c_wre = 0; c_rad = 6'd20;
    #1;
    chk("wide_wr20", do4, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sdp_gen.md
RAM_SDP_GEN -- requirements
Module: ram_sdp_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 2: word width in bits, 1..64.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter OUT_REG, default 0: 0 = asynchronous read, 1 = registered read.
REQ-004 SHALL have parameter RDW_MODE, default 0: same-address read-during-write; 0 = old data, 1 = new data (bypass).
REQ-005 SHALL have parameter INIT_VAL [DATA_W-1:0], default 0: value written by every clear sweep.
REQ-006 Port list, in this order:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CLR  in  1  request a clear sweep.
- BUSY  out  1  clear sweep in progress.
- WRE  in  1  write enable.
- WAD  in  ADDR_W  write address.
- DI  in  DATA_W  write data.
- RE  in  1  read enable; used only when OUT_REG=1.
- RAD  in  ADDR_W  read address.
- DO  out  DATA_W  read data.

Function
REQ-007 SHALL use a two-state FSM: CLEAR, IDLE.
REQ-008 In CLEAR: each cycle writes INIT_VAL at counter address, then increments the counter; after writing DEPTH-1, next state SHALL be IDLE.
REQ-009 BUSY SHALL be 1 exactly while the state is CLEAR; after RESET release BUSY stays high for DEPTH rising edges.
REQ-010 CLR=1 in IDLE: next state SHALL be CLEAR with counter 0.
REQ-011 CLR=1 in CLEAR: counter SHALL restart at 0 (sweep restarts).
REQ-012 WRE SHALL be ignored while BUSY=1; in IDLE, WRE=1 writes DI to WAD on the rising edge.
REQ-013 OUT_REG=0: DO SHALL equal mem[RAD] combinationally (zero latency).
REQ-014 OUT_REG=1: on a rising edge with RE=1, DO SHALL load mem[RAD]; with RE=0, DO holds (latency 1).
REQ-015 RDW_MODE=1 with WRE=1, IDLE and RAD==WAD: the read path SHALL return DI (combinationally when OUT_REG=0, registered when OUT_REG=1).
REQ-016 RDW_MODE=0 in the same case: the read path SHALL return the pre-write contents.
REQ-017 While BUSY=1, the read path SHALL return INIT_VAL regardless of RAD.

Reset
REQ-018 RESET=1 SHALL asynchronously set state CLEAR, counter 0, BUSY 1 and registered DO 0; array contents are not reset directly.
REQ-019 RESET asserted mid-sweep or mid-write SHALL abort it; a full sweep restarts from address 0 after release.

Configuration
REQ-020 Macro RAM_SDP_GEN_PARITY_EN, when defined, SHALL add:
- one even-parity bit per word, stored alongside the data;
- input PINJ (1 bit): when 1 during a write, the stored parity bit is inverted;
- output PERR (1 bit): 1 when the read word's parity mismatches, time-aligned with DO (reset 0; 0 while BUSY).
REQ-021 Without RAM_SDP_GEN_PARITY_EN: no parity storage, no PINJ/PERR ports, and behaviour otherwise identical.

Structure
REQ-022 Package ram_sdp_gen_pkg SHALL hold the FSM state enum and the RDW_MODE constants (RDW_OLD=0, RDW_NEW=1).
REQ-023 The clear FSM and its counter SHALL be sub-module ram_sdp_gen_clr (outputs: BUSY, clear address, clear write enable).

Verification
REQ-024 Defaults; release RESET -> BUSY high 16 cycles, then low; DO=0 at all 16 addresses.
REQ-025 OUT_REG=0, IDLE; write 2'b11 to 5 -> DO=2'b11 with RAD=5 right after the edge; RAD=4 -> 2'b00.
REQ-026 OUT_REG=1, RDW_MODE=1, WAD=RAD=3, DI=2'b10, WRE=RE=1 -> DO=2'b10 after one edge; same with RDW_MODE=0 -> DO=2'b00.
REQ-027 INIT_VAL=2'b01; CLR pulse at cycle 5 of a sweep -> BUSY stays high 16 more cycles; a WRE to address 2 during BUSY is ignored; all addresses read 2'b01 afterwards.
REQ-028 With RAM_SDP_GEN_PARITY_EN: write 2'b01 to 7 with PINJ=1 -> reading 7 gives PERR=1; a normal write of 2'b01 to 8 -> PERR=0.
REQ-029 DATA_W=8, ADDR_W=6; assert RESET mid-sweep (counter=20) -> BUSY high 64 cycles after release, DO=0.
